// File: rtl/instr_byte_fifo.sv
// Assembles 16-bit instructions from byte strobes (high byte first) into a small FIFO, head offered valid/ready.
// Optional macro INSTR_FIFO_DROP_CNT_EN enables a saturating dropped-instruction counter on drop_cnt.
module instr_byte_fifo #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    byte_in,
    input  logic          byte_stb,
    input  logic          flush,
    output logic [15:0]   instr_out,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW:0]   fill_level,
    output logic          overflow,
    output logic          resync,
    output logic [7:0]    drop_cnt
);
    typedef enum logic {S_HI, S_LO} state_t;

    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [7:0]  TIMER_END = 8'(TIMEOUT - 1);

    state_t         r_state;
    logic [7:0]     r_hi;
    logic [7:0]     r_timer;
    logic [15:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           r_overflow;
    logic           r_resync;

    logic           w_pop;
    logic           w_word_rdy;
    logic           w_room;
    logic           w_push;
    logic           w_drop;
    logic [15:0]    w_word;

    assign w_pop      = (r_count != '0) && instr_ready;
    assign w_word_rdy = (r_state == S_LO) && byte_stb;
    // A full FIFO still accepts a word when the head leaves in the same cycle
    assign w_room     = (r_count < FULL_CNT) || w_pop;
    assign w_push     = w_word_rdy && w_room;
    assign w_drop     = w_word_rdy && !w_room;
    assign w_word     = {r_hi, byte_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_HI;
            r_hi       <= 8'h00;
            r_timer    <= 8'h00;
            r_resync   <= 1'b0;
        end else if (flush) begin
            r_state    <= S_HI;
            r_timer    <= 8'h00;
            r_resync   <= 1'b0;
        end else begin
            r_resync <= 1'b0;
            case (r_state)
                S_HI: begin
                    if (byte_stb) begin
                        r_hi    <= byte_in;
                        r_timer <= 8'h00;
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    if (byte_stb) begin
                        r_state <= S_HI;
                    end else if (r_timer == TIMER_END) begin
                        r_resync <= 1'b1;
                        r_state  <= S_HI;
                    end else begin
                        r_timer <= r_timer + 8'h01;
                    end
                end
                default: r_state <= S_HI;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow <= r_overflow | w_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && w_push) r_mem[r_wr_ptr] <= w_word;
    end

`ifdef INSTR_FIFO_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= 8'h00;
        end else if (flush) begin
            r_drop_cnt <= 8'h00;
        end else if (w_drop && r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'h01;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 8'h00;
`endif

    assign instr_valid = (r_count != '0);
    assign instr_out   = (r_count != '0) ? r_mem[r_rd_ptr] : 16'h0000;
    assign fill_level  = r_count;
    assign overflow    = r_overflow;
    assign resync      = r_resync;
endmodule

// File: tb/tb_instr_byte_fifo.sv
// Bench for instr_byte_fifo (DEPTH=4, TIMEOUT=8): directed scenarios plus random traffic against a queue model.
module tb_instr_byte_fifo;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int AW      = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_stb = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [AW:0] fill_level;
    logic        overflow;
    logic        resync;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    instr_byte_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_stb(byte_stb), .flush(flush),
        .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .fill_level(fill_level), .overflow(overflow), .resync(resync), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: queue of words plus the half-assembled instruction
    logic [15:0] m_q[$];
    bit          m_have_hi;
    logic [7:0]  m_hi;
    int          m_idle;
    bit          m_ovf;
    int          m_drops;
    bit          m_resync;

    function automatic void model_clear();
        m_q.delete();
        m_have_hi = 0;
        m_hi      = 8'h00;
        m_idle    = 0;
        m_ovf     = 0;
        m_drops   = 0;
        m_resync  = 0;
    endfunction

    function automatic void model_step(input bit s, input logic [7:0] b, input bit r, input bit f);
        bit was_full;
        bit pop;
        m_resync = 0;
        if (f) begin
            model_clear();
            return;
        end
        pop      = (m_q.size() > 0) && r;
        was_full = (m_q.size() >= DEPTH);
        if (pop) void'(m_q.pop_front());
        if (!m_have_hi) begin
            if (s) begin
                m_have_hi = 1;
                m_hi      = b;
                m_idle    = 0;
            end
        end else if (s) begin
            m_have_hi = 0;
            if (!was_full || pop) m_q.push_back({m_hi, b});
            else begin
                m_ovf   = 1;
                m_drops = m_drops + 1;
            end
        end else begin
            m_idle = m_idle + 1;
            if (m_idle == TIMEOUT) begin
                m_have_hi = 0;
                m_resync  = 1;
            end
        end
    endfunction

    function automatic logic [15:0] exp_out();
        return (m_q.size() > 0) ? m_q[0] : 16'h0000;
    endfunction

    function automatic logic [7:0] exp_drop();
`ifdef INSTR_FIFO_DROP_CNT_EN
        return (m_drops > 255) ? 8'hFF : 8'(m_drops);
`else
        return 8'h00;
`endif
    endfunction

    task automatic cycle(input bit s, input logic [7:0] b, input bit r, input bit f);
        byte_stb    = s;
        byte_in     = b;
        instr_ready = r;
        flush       = f;
        model_step(s, b, r, f);
        @(posedge clk);
        #1;
        byte_stb    = 1'b0;
        instr_ready = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({instr_valid, instr_out, fill_level, overflow, resync, drop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b out=%h fill=%0d ovf=%b resync=%b drop=%0d, want all 0",
                     instr_valid, instr_out, fill_level, overflow, resync, drop_cnt);
        end
    endtask

    task automatic test_basic();
        do_reset();
        cycle(1, 8'hA5, 0, 0);
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL basic_hi_only_valid: got %b want 0", instr_valid);
        end
        cycle(1, 8'h3C, 0, 0);
        checks++;
        if (instr_valid !== 1'b1 || instr_out !== 16'hA53C || fill_level !== 3'd1) begin
            errors++;
            $display("FAIL basic_word: got valid=%b out=%h fill=%0d want 1 a53c 1", instr_valid, instr_out, fill_level);
        end
        cycle(0, 8'h00, 1, 0);
        checks++;
        if (instr_valid !== 1'b0 || instr_out !== 16'h0000) begin
            errors++; $display("FAIL basic_pop: got valid=%b out=%h want 0 0000", instr_valid, instr_out);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] w;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cycle(1, 8'(i), 0, 0);
            cycle(1, 8'(i), 0, 0);
        end
        checks++;
        if (fill_level !== 3'd4 || overflow !== 1'b1 || instr_out !== 16'h0101) begin
            errors++;
            $display("FAIL ovf_full: got fill=%0d ovf=%b head=%h want 4 1 0101", fill_level, overflow, instr_out);
        end
        checks++;
`ifdef INSTR_FIFO_DROP_CNT_EN
        if (drop_cnt !== 8'd1) begin
            errors++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt);
        end
`else
        if (drop_cnt !== 8'd0) begin
            errors++; $display("FAIL ovf_drop_cnt: got %0d want 0", drop_cnt);
        end
`endif
        for (int i = 1; i <= 4; i++) begin
            w = {8'(i), 8'(i)};
            checks++;
            if (instr_out !== w) begin
                errors++; $display("FAIL ovf_pop_order%0d: got %h want %h", i, instr_out, w);
            end
            cycle(0, 8'h00, 1, 0);
        end
        checks++;
        if (instr_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_drained: got valid=%b ovf=%b want 0 1", instr_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cycle(1, 8'h10, 0, 0);
            cycle(1, 8'(i), 0, 0);
        end
        cycle(1, 8'hEE, 0, 0);
        cycle(1, 8'hFF, 1, 0);
        checks++;
        if (fill_level !== 3'd4 || overflow !== 1'b0 || instr_out !== 16'h1002) begin
            errors++;
            $display("FAIL fullpp: got fill=%0d ovf=%b head=%h want 4 0 1002", fill_level, overflow, instr_out);
        end
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);
        checks++;
        if (instr_out !== 16'hEEFF || fill_level !== 3'd1) begin
            errors++; $display("FAIL fullpp_tail: got %h fill=%0d want eeff 1", instr_out, fill_level);
        end
    endtask

    task automatic test_timeout();
        int pulses;
        int pulse_at;
        do_reset();
        cycle(1, 8'h12, 0, 0);
        pulses   = 0;
        pulse_at = -1;
        for (int i = 1; i <= 12; i++) begin
            cycle(0, 8'h00, 0, 0);
            if (resync === 1'b1) begin
                pulses++;
                pulse_at = i;
            end
        end
        checks++;
        if (pulses != 1 || pulse_at != TIMEOUT) begin
            errors++; $display("FAIL timeout_resync: got %0d pulses at idle %0d want 1 at %0d", pulses, pulse_at, TIMEOUT);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_no_push: got valid=%b want 0", instr_valid);
        end
        cycle(1, 8'h34, 0, 0);
        cycle(1, 8'h56, 0, 0);
        checks++;
        if (instr_out !== 16'h3456) begin
            errors++; $display("FAIL timeout_resume: got %h want 3456", instr_out);
        end
        // Strobe arriving on the last idle cycle still completes the word
        cycle(1, 8'h9A, 0, 0);
        for (int i = 1; i < TIMEOUT; i++) cycle(0, 8'h00, 0, 0);
        cycle(1, 8'hBC, 0, 0);
        checks++;
        if (resync !== 1'b0 || fill_level !== 3'd2) begin
            errors++; $display("FAIL timeout_edge: got resync=%b fill=%0d want 0 2", resync, fill_level);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1, 8'h77, 0, 0);
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if ({instr_valid, instr_out, fill_level, overflow, resync, drop_cnt} !== '0) begin
            errors++; $display("FAIL rst_mid_async: got valid=%b out=%h fill=%0d, want 0", instr_valid, instr_out, fill_level);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1, 8'hBE, 0, 0);
        cycle(1, 8'hEF, 0, 0);
        checks++;
        if (instr_out !== 16'hBEEF || fill_level !== 3'd1) begin
            errors++; $display("FAIL rst_mid_word: got %h fill=%0d want beef 1", instr_out, fill_level);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cycle(1, 8'h20, 0, 0);
            cycle(1, 8'(i), 0, 0);
        end
        cycle(0, 8'h00, 1, 0);
        cycle(1, 8'h44, 0, 0);
        checks++;
        if (fill_level !== 3'd3 || overflow !== 1'b1) begin
            errors++; $display("FAIL flush_setup: got fill=%0d ovf=%b want 3 1", fill_level, overflow);
        end
        cycle(1, 8'h55, 1, 1);
        checks++;
        if (fill_level !== 3'd0 || instr_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL flush_clear: got fill=%0d valid=%b ovf=%b drop=%0d want 0 0 0 0", fill_level, instr_valid, overflow, drop_cnt);
        end
        cycle(1, 8'h66, 0, 0);
        cycle(1, 8'h77, 0, 0);
        checks++;
        if (instr_out !== 16'h6677 || fill_level !== 3'd1) begin
            errors++; $display("FAIL flush_hi_first: got %h fill=%0d want 6677 1", instr_out, fill_level);
        end
    endtask

    task automatic test_random();
        int stb_pct;
        int rdy_pct;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                stb_pct = $urandom_range(5, 100);
                rdy_pct = $urandom_range(0, 100);
            end
            cycle($urandom_range(0, 99) < stb_pct, 8'($urandom), $urandom_range(0, 99) < rdy_pct,
                  $urandom_range(0, 199) == 0);
            checks++;
            if (instr_valid !== (m_q.size() > 0) || instr_out !== exp_out() ||
                fill_level !== (AW+1)'(m_q.size()) || overflow !== m_ovf ||
                resync !== m_resync || drop_cnt !== exp_drop()) begin
                errors++;
                $display("FAIL random_cycle%0d: got v=%b o=%h f=%0d ov=%b rs=%b d=%0d want v=%b o=%h f=%0d ov=%b rs=%b d=%0d",
                         i, instr_valid, instr_out, fill_level, overflow, resync, drop_cnt,
                         m_q.size() > 0, exp_out(), m_q.size(), m_ovf, m_resync, exp_drop());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_reset_mid();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
